// File: rtl/mod_mult_pipe.sv
// rtl/mod_mult_pipe.sv - multi-lane pipelined Barrett modular multiplier
//
// Purpose: computes result lane i = (a_i * b_i) mod q for LANES independent
// lanes that share one valid/ready handshake, one tag and one modulus. The
// pipeline has MUL_DP+4 register stages:
//   stage 0           : operand, tag and q/mu capture
//   stages 1..MUL_DP  : product p = a*b, then delayed
//   stage MUL_DP+1    : Barrett quotient estimate qhat
//   stage MUL_DP+2    : remainder estimate r = p - qhat*q (in [0,3q))
//   stage MUL_DP+3    : final correction (at most two subtractions of q)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake (a, b, in_tag)
//   a, b                LANES*K packed operands, lane i at [i*K +: K]
//   in_tag              sideband returned with the beat on out_tag
//   out_valid/out_ready result beat handshake (result, out_tag)
//   cfg_we/cfg_q/cfg_mu modulus and Barrett constant load, idle only
//   busy                a beat is in flight or held at the output
//   cfg_err             one-cycle pulse when a cfg_we is rejected
module mod_mult_pipe #(
  parameter int            K          = 32,
  parameter int            LANES      = 4,
  parameter int            MUL_DP     = 4,
  parameter int            TAG_W      = 8,
  parameter logic [K-1:0]  Q_DEFAULT  = 32'hFFFF_FFFB,
  parameter logic [K:0]    MU_DEFAULT = 33'h1_0000_0005
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*K-1:0]   a,
  input  logic [LANES*K-1:0]   b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*K-1:0]   result,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 cfg_we,
  input  logic [K-1:0]         cfg_q,
  input  logic [K:0]           cfg_mu,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int L  = MUL_DP + 4;
  localparam int SH = MUL_DP + 1;
  localparam int SR = MUL_DP + 2;
  localparam int SO = MUL_DP + 3;

  logic [K-1:0]     q_cur;
  logic [K:0]       mu_cur;
  logic             ready_en;
  logic [L-1:0]     v;
  logic [L-1:0]     en;
  logic             stall;
  logic             accept;

  logic [TAG_W-1:0] tag_p [L];
  logic [K-1:0]     q_p   [SR+1];
  logic [K:0]       mu_p  [MUL_DP+1];

  logic [K-1:0]     a_s   [LANES];
  logic [K-1:0]     b_s   [LANES];
  logic [2*K-1:0]   p_d   [MUL_DP][LANES];
  logic [K+1:0]     p_h   [LANES];
  logic [K:0]       qh_h  [LANES];
  logic [K+1:0]     r_r   [LANES];
  logic [K-1:0]     res   [LANES];

  logic [2*K-1:0]   mul_c [LANES];
  logic [K:0]       qh_c  [LANES];
  logic [K+1:0]     r_c   [LANES];
  logic [K-1:0]     red_c [LANES];

  // ready_en keeps in_ready low until the first edge after reset release.
  assign stall     = v[SO] && !out_ready;
  assign in_ready  = ready_en && !stall;
  assign accept    = in_valid && in_ready;
  assign busy      = |v;
  assign out_valid = v[SO];
  assign out_tag   = tag_p[SO];

  // A stage may load when some stage at or after it is empty, or the output
  // drains this cycle. Empty stages thus close up behind a stalled output
  // without ever overwriting a valid beat.
  always_comb begin
    en = '0;
    for (int i = 0; i < L; i++) begin
      en[i] = out_ready;
      for (int j = i; j < L; j++) begin
        if (!v[j]) en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [2*K+1:0] t;
    logic [K+1:0]   u;
    t = '0;
    u = '0;
    for (int l = 0; l < LANES; l++) begin
      mul_c[l] = {{K{1'b0}}, a_s[l]} * {{K{1'b0}}, b_s[l]};
      // qhat = floor(floor(p / 2^(K-1)) * mu / 2^(K+1)); fits in K+1 bits.
      t = {{(K+1){1'b0}}, p_d[MUL_DP-1][l][2*K-1:K-1]} *
          {{(K+1){1'b0}}, mu_p[MUL_DP]};
      qh_c[l] = (K+1)'(t >> (K+1));
      // True remainder is below 3q < 2^(K+2), so K+2-bit wrapping is exact.
      r_c[l] = p_h[l] - ({1'b0, qh_h[l]} * {2'b00, q_p[SH]});
      u = r_r[l];
      if (u >= {2'b00, q_p[SR]}) u = u - {2'b00, q_p[SR]};
      if (u >= {2'b00, q_p[SR]}) u = u - {2'b00, q_p[SR]};
      red_c[l] = u[K-1:0];
    end
  end

  always_comb begin
    result = '0;
    for (int l = 0; l < LANES; l++) result[l*K +: K] = res[l];
  end

  // Control: handshake valids, modulus register and config error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      v        <= '0;
      q_cur    <= Q_DEFAULT;
      mu_cur   <= MU_DEFAULT;
      cfg_err  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      cfg_err  <= 1'b0;
      if (cfg_we) begin
        if (!busy && !in_valid) begin
          q_cur  <= cfg_q;
          mu_cur <= cfg_mu;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (en[0]) v[0] <= accept;
      for (int i = 1; i < L; i++) begin
        if (en[i]) v[i] <= v[i-1];
      end
    end
  end

  // Datapath: each stage captures from its predecessor whenever it may load.
  // q/mu travel with the beat so every beat uses the values from accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) tag_p[i] <= '0;
      for (int i = 0; i <= SR; i++) q_p[i] <= '0;
      for (int i = 0; i <= MUL_DP; i++) mu_p[i] <= '0;
      for (int l = 0; l < LANES; l++) begin
        a_s[l]  <= '0;
        b_s[l]  <= '0;
        p_h[l]  <= '0;
        qh_h[l] <= '0;
        r_r[l]  <= '0;
        res[l]  <= '0;
        for (int i = 0; i < MUL_DP; i++) p_d[i][l] <= '0;
      end
    end else begin
      if (en[0]) begin
        tag_p[0] <= in_tag;
        q_p[0]   <= q_cur;
        mu_p[0]  <= mu_cur;
        for (int l = 0; l < LANES; l++) begin
          a_s[l] <= a[l*K +: K];
          b_s[l] <= b[l*K +: K];
        end
      end
      for (int i = 1; i < L; i++) begin
        if (en[i]) tag_p[i] <= tag_p[i-1];
      end
      for (int i = 1; i <= SR; i++) begin
        if (en[i]) q_p[i] <= q_p[i-1];
      end
      for (int i = 1; i <= MUL_DP; i++) begin
        if (en[i]) mu_p[i] <= mu_p[i-1];
      end
      for (int l = 0; l < LANES; l++) begin
        if (en[1]) p_d[0][l] <= mul_c[l];
        for (int i = 1; i < MUL_DP; i++) begin
          if (en[i+1]) p_d[i][l] <= p_d[i-1][l];
        end
        if (en[SH]) begin
          p_h[l]  <= p_d[MUL_DP-1][l][K+1:0];
          qh_h[l] <= qh_c[l];
        end
        if (en[SR]) r_r[l] <= r_c[l];
        if (en[SO]) res[l] <= red_c[l];
      end
    end
  end

endmodule
